// File: rtl/bus_fabric_pkg.sv
// ---------------------------------------------------------------------------
// bus_fabric_pkg
// Shared types and width helpers for the CPU data-side bus fabric.
//   fsm_state_t : transaction state (IDLE -> ACCESS -> RESPOND -> IDLE)
//   be_width()  : byte-enable width for a given data width
//   idx_width() : width of a slave index, never narrower than one bit
// ---------------------------------------------------------------------------
package bus_fabric_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2
   } fsm_state_t;

   function automatic int be_width(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int idx_width(input int num_slaves);
      return (num_slaves > 1) ? $clog2(num_slaves) : 1;
   endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// ---------------------------------------------------------------------------
// bus_addr_decoder
// Combinational base/mask address decoder. Channel i hits when
// (address & mask[i]) == base[i]; when regions overlap the lowest index wins.
// Ports:
//   address   in  byte address from the master
//   base_addr in  packed region bases, channel 0 in the LSBs
//   addr_mask in  packed decode masks, channel 0 in the LSBs
//   hit       out at least one channel matches
//   index     out winning channel (0 when no hit)
//   offset    out address with the region mask bits cleared
// ---------------------------------------------------------------------------
module bus_addr_decoder
   import bus_fabric_pkg::*;
#(
   parameter int NUM_SLAVES = 3,
   parameter int ADDR_W     = 10,
   parameter int IDX_W      = idx_width(NUM_SLAVES)
)(
   input  logic [ADDR_W-1:0]            address,
   input  logic [NUM_SLAVES*ADDR_W-1:0] base_addr,
   input  logic [NUM_SLAVES*ADDR_W-1:0] addr_mask,
   output logic                         hit,
   output logic [IDX_W-1:0]             index,
   output logic [ADDR_W-1:0]            offset
);

   // Priority decode: scan from the highest channel down so the lowest match is kept last.
   always_comb begin
      hit    = 1'b0;
      index  = '0;
      offset = address;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((address & addr_mask[i*ADDR_W +: ADDR_W]) == base_addr[i*ADDR_W +: ADDR_W]) begin
            hit    = 1'b1;
            index  = IDX_W'(i);
            offset = address & ~addr_mask[i*ADDR_W +: ADDR_W];
         end else begin
            // no match on this channel: keep the result from higher channels
            hit    = hit;
         end
      end
   end

endmodule

// File: rtl/bus_fabric.sv
// ---------------------------------------------------------------------------
// bus_fabric
// Connects the single CPU data master to NUM_SLAVES memory-mapped slaves.
// A request sampled in IDLE is decoded; a hit opens an ACCESS phase with a
// held one-hot strobe until the selected slave acks or the timeout expires,
// then RESPOND pulses master_ready for one cycle with data and error.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   master_read/master_write      request (sampled in IDLE only)
//   master_address/_byte_enable/_writedata   request payload
//   master_readdata/_ready/_error completion (data/error valid with ready)
//   slave_read/slave_write        one-hot strobes, held during ACCESS
//   slave_address/_byte_enable/_writedata    latched offset and payload
//   slave_readdata/slave_ack      per-channel return data and completion
// ---------------------------------------------------------------------------
module bus_fabric
   import bus_fabric_pkg::*;
#(
   parameter int                            NUM_SLAVES = 3,
   parameter int                            ADDR_W     = 10,
   parameter int                            DATA_W     = 32,
   parameter logic [NUM_SLAVES*ADDR_W-1:0]  BASE_ADDR  = {10'h210, 10'h200, 10'h000},
   parameter logic [NUM_SLAVES*ADDR_W-1:0]  ADDR_MASK  = {10'h3F0, 10'h3F0, 10'h200},
   parameter int                            TIMEOUT    = 16
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         master_read,
   input  logic                         master_write,
   input  logic [ADDR_W-1:0]            master_address,
   input  logic [DATA_W/8-1:0]          master_byte_enable,
   input  logic [DATA_W-1:0]            master_writedata,
   output logic [DATA_W-1:0]            master_readdata,
   output logic                         master_ready,
   output logic                         master_error,
   output logic [NUM_SLAVES-1:0]        slave_read,
   output logic [NUM_SLAVES-1:0]        slave_write,
   output logic [ADDR_W-1:0]            slave_address,
   output logic [DATA_W/8-1:0]          slave_byte_enable,
   output logic [DATA_W-1:0]            slave_writedata,
   input  logic [NUM_SLAVES*DATA_W-1:0] slave_readdata,
   input  logic [NUM_SLAVES-1:0]        slave_ack
);

   localparam int               BE_W     = be_width(DATA_W);
   localparam int               IDX_W    = idx_width(NUM_SLAVES);
   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   fsm_state_t            state_r, next_state_s;
   logic [CNT_W-1:0]      cnt_r, cnt_nx_s;
   logic [IDX_W-1:0]      idx_r, idx_nx_s;
   logic                  is_write_r, is_write_nx_s;
   logic [ADDR_W-1:0]     addr_r, addr_nx_s;
   logic [BE_W-1:0]       be_r, be_nx_s;
   logic [DATA_W-1:0]     wdata_r, wdata_nx_s;
   logic [DATA_W-1:0]     rdata_r, rdata_nx_s;
   logic                  ready_r, ready_nx_s;
   logic                  error_r, error_nx_s;
   logic [NUM_SLAVES-1:0] rd_strobe_r, rd_strobe_nx_s;
   logic [NUM_SLAVES-1:0] wr_strobe_r, wr_strobe_nx_s;

   logic                  dec_hit_s;
   logic [IDX_W-1:0]      dec_idx_s;
   logic [ADDR_W-1:0]     dec_off_s;
   logic [NUM_SLAVES-1:0] dec_onehot_s, sel_onehot_s;
   logic [DATA_W-1:0]     sel_rdata_s;
   logic                  ack_sel_s, timeout_s, req_one_s, req_both_s;

   bus_addr_decoder #(
      .NUM_SLAVES (NUM_SLAVES),
      .ADDR_W     (ADDR_W),
      .IDX_W      (IDX_W)
   ) u_decoder (
      .address    (master_address),
      .base_addr  (BASE_ADDR),
      .addr_mask  (ADDR_MASK),
      .hit        (dec_hit_s),
      .index      (dec_idx_s),
      .offset     (dec_off_s)
   );

   assign req_one_s  = master_read ^ master_write;
   assign req_both_s = master_read & master_write;
   assign ack_sel_s  = |(slave_ack & sel_onehot_s);
   assign timeout_s  = (cnt_r == CNT_LAST);

   // One-hot forms of the decoded and latched index, and the latched channel's read data.
   always_comb begin
      dec_onehot_s = '0;
      sel_onehot_s = '0;
      sel_rdata_s  = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         dec_onehot_s[i] = (dec_idx_s == IDX_W'(i));
         sel_onehot_s[i] = (idx_r == IDX_W'(i));
         sel_rdata_s     = sel_rdata_s | (slave_readdata[i*DATA_W +: DATA_W] & {DATA_W{sel_onehot_s[i]}});
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decision; an ack wins over a simultaneous timeout.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (req_one_s) begin
               next_state_s = dec_hit_s ? ACCESS : RESPOND;
            end else if (req_both_s) begin
               next_state_s = RESPOND;
            end else begin
               next_state_s = IDLE;
            end
         end
         ACCESS: begin
            if (ack_sel_s || timeout_s) begin
               next_state_s = RESPOND;
            end else begin
               next_state_s = ACCESS;
            end
         end
         RESPOND: next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Next values of the output and latch registers, so every output leaves a flop.
   always_comb begin
      cnt_nx_s       = cnt_r;
      idx_nx_s       = idx_r;
      is_write_nx_s  = is_write_r;
      addr_nx_s      = addr_r;
      be_nx_s        = be_r;
      wdata_nx_s     = wdata_r;
      rdata_nx_s     = '0;
      ready_nx_s     = 1'b0;
      error_nx_s     = 1'b0;
      rd_strobe_nx_s = '0;
      wr_strobe_nx_s = '0;
      case (state_r)
         IDLE: begin
            cnt_nx_s = '0;
            if (req_one_s) begin
               idx_nx_s      = dec_idx_s;
               is_write_nx_s = master_write;
               addr_nx_s     = dec_off_s;
               be_nx_s       = master_byte_enable;
               wdata_nx_s    = master_writedata;
               if (dec_hit_s) begin
                  rd_strobe_nx_s = master_write ? '0 : dec_onehot_s;
                  wr_strobe_nx_s = master_write ? dec_onehot_s : '0;
               end else begin
                  ready_nx_s = 1'b1;
                  error_nx_s = 1'b1;
               end
            end else if (req_both_s) begin
               ready_nx_s = 1'b1;
               error_nx_s = 1'b1;
            end else begin
               ready_nx_s = 1'b0;
            end
         end
         ACCESS: begin
            cnt_nx_s = cnt_r + CNT_W'(1);
            if (ack_sel_s) begin
               ready_nx_s = 1'b1;
               rdata_nx_s = is_write_r ? '0 : sel_rdata_s;
            end else if (timeout_s) begin
               ready_nx_s = 1'b1;
               error_nx_s = 1'b1;
            end else begin
               rd_strobe_nx_s = rd_strobe_r;
               wr_strobe_nx_s = wr_strobe_r;
            end
         end
         RESPOND: cnt_nx_s = '0;
         default: cnt_nx_s = '0;
      endcase
   end

   // Output and latch registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r       <= '0;
         idx_r       <= '0;
         is_write_r  <= 1'b0;
         addr_r      <= '0;
         be_r        <= '0;
         wdata_r     <= '0;
         rdata_r     <= '0;
         ready_r     <= 1'b0;
         error_r     <= 1'b0;
         rd_strobe_r <= '0;
         wr_strobe_r <= '0;
      end else begin
         cnt_r       <= cnt_nx_s;
         idx_r       <= idx_nx_s;
         is_write_r  <= is_write_nx_s;
         addr_r      <= addr_nx_s;
         be_r        <= be_nx_s;
         wdata_r     <= wdata_nx_s;
         rdata_r     <= rdata_nx_s;
         ready_r     <= ready_nx_s;
         error_r     <= error_nx_s;
         rd_strobe_r <= rd_strobe_nx_s;
         wr_strobe_r <= wr_strobe_nx_s;
      end
   end

   assign master_readdata   = rdata_r;
   assign master_ready      = ready_r;
   assign master_error      = error_r;
   assign slave_read        = rd_strobe_r;
   assign slave_write       = wr_strobe_r;
   assign slave_address     = addr_r;
   assign slave_byte_enable = be_r;
   assign slave_writedata   = wdata_r;

endmodule

// File: tb/tb_bus_fabric.sv
// ---------------------------------------------------------------------------
// tb_bus_fabric
// Directed and randomized transactions against bus_fabric with default
// parameters. Expected results come from a transaction-level model: the
// address map table, "ACCESS lasts min(ack_delay+1, TIMEOUT) cycles", and
// the completion rules. Cycle n counts sampling points after the request edge.
// ---------------------------------------------------------------------------
module tb_bus_fabric;

   localparam int NS = 3;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int BW = 4;
   localparam int TO = 16;
   localparam int BASE_TBL [NS] = '{32'h000, 32'h200, 32'h210};
   localparam int MASK_TBL [NS] = '{32'h200, 32'h3F0, 32'h3F0};

   logic           clk = 1'b0;
   logic           rst;
   logic           master_read, master_write;
   logic [AW-1:0]  master_address;
   logic [BW-1:0]  master_byte_enable;
   logic [DW-1:0]  master_writedata;
   logic [DW-1:0]  master_readdata;
   logic           master_ready, master_error;
   logic [NS-1:0]  slave_read, slave_write;
   logic [AW-1:0]  slave_address;
   logic [BW-1:0]  slave_byte_enable;
   logic [DW-1:0]  slave_writedata;
   logic [NS*DW-1:0] slave_readdata;
   logic [NS-1:0]  slave_ack;

   int n_checks = 0;
   int n_fail   = 0;
   int txn_id   = 0;

   bus_fabric dut (
      .clk                (clk),
      .rst                (rst),
      .master_read        (master_read),
      .master_write       (master_write),
      .master_address     (master_address),
      .master_byte_enable (master_byte_enable),
      .master_writedata   (master_writedata),
      .master_readdata    (master_readdata),
      .master_ready       (master_ready),
      .master_error       (master_error),
      .slave_read         (slave_read),
      .slave_write        (slave_write),
      .slave_address      (slave_address),
      .slave_byte_enable  (slave_byte_enable),
      .slave_writedata    (slave_writedata),
      .slave_readdata     (slave_readdata),
      .slave_ack          (slave_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s (txn %0d) observed=%0h expected=%0h", tag, txn_id, obs, exp);
      end
   endtask

   // Reference address map: first table entry that matches wins, -1 when unmapped.
   function automatic int ref_decode(input int addr);
      for (int i = 0; i < NS; i++) begin
         if ((addr & MASK_TBL[i]) == BASE_TBL[i]) return i;
      end
      return -1;
   endfunction

   // One complete transaction; delay >= TO means the slave never acks.
   task automatic run_txn(input logic rd, input logic wr, input int addr, input int be,
                          input int wdata, input int delay);
      int ch, acc_len, lat_exp, strb_cnt, strb_bad, lat_seen, exp_addr;
      logic [NS-1:0] oh, noise;
      logic [5:0] exp_strb;
      logic err_exp, got_err;
      logic [31:0] rd_exp, got_rdata;
      logic [31:0] rdata [NS];
      txn_id++;
      ch       = (rd ^ wr) ? ref_decode(addr) : -1;
      oh       = (ch >= 0) ? NS'(1 << ch) : '0;
      exp_strb = rd ? {3'b000, oh} : {oh, 3'b000};
      exp_addr = (ch >= 0) ? ((addr & ~MASK_TBL[ch]) & 32'h3FF) : 0;
      for (int i = 0; i < NS; i++) begin
         rdata[i] = $urandom;
         slave_readdata[i*DW +: DW] = rdata[i];
      end
      if (ch < 0) begin
         acc_len = 0;          lat_exp = 1;      err_exp = 1'b1; rd_exp = 32'h0;
      end else if (delay < TO) begin
         acc_len = delay + 1;  lat_exp = delay + 2; err_exp = 1'b0;
         rd_exp  = rd ? rdata[ch] : 32'h0;
      end else begin
         acc_len = TO;         lat_exp = TO + 1; err_exp = 1'b1; rd_exp = 32'h0;
      end
      @(negedge clk);
      master_read        = rd;
      master_write       = wr;
      master_address     = AW'(addr);
      master_byte_enable = BW'(be);
      master_writedata   = 32'(wdata);
      strb_cnt = 0; strb_bad = 0; lat_seen = 0; got_rdata = 32'h0; got_err = 1'b0;
      for (int n = 1; n <= 40 && lat_seen == 0; n++) begin
         @(negedge clk);
         // garbage payload while busy must not reach the slave side
         master_read        = 1'b0;
         master_write       = 1'b0;
         master_address     = AW'($urandom);
         master_byte_enable = BW'($urandom);
         master_writedata   = $urandom;
         if ({slave_write, slave_read} != 6'b000000) begin
            strb_cnt++;
            if ({slave_write, slave_read} !== exp_strb || 32'(slave_address) !== 32'(exp_addr) ||
                32'(slave_byte_enable) !== 32'(be & 15) || slave_writedata !== 32'(wdata)) begin
               strb_bad++;
            end
         end
         if (master_ready === 1'b1) begin
            lat_seen  = n;
            got_rdata = master_readdata;
            got_err   = master_error;
         end
         noise = NS'($urandom) & ~oh;
         slave_ack = ({slave_write, slave_read} != 6'b000000 && strb_cnt == delay + 1) ? (oh | noise) : noise;
      end
      @(negedge clk);
      slave_ack = '0;
      check("ready_latency", 32'(lat_seen), 32'(lat_exp));
      check("strobe_cycles", 32'(strb_cnt), 32'(acc_len));
      check("strobe_payload_bad_cycles", 32'(strb_bad), 32'h0);
      check("error", 32'(got_err), 32'(err_exp));
      check("readdata", got_rdata, rd_exp);
      check("ready_single_pulse", 32'(master_ready), 32'h0);
      check("strobe_idle_after", 32'({slave_write, slave_read}), 32'h0);
   endtask

   initial begin
      int cnt;
      int r;
      rst = 1'b1; master_read = 1'b0; master_write = 1'b0; master_address = '0;
      master_byte_enable = '0; master_writedata = '0; slave_readdata = '0; slave_ack = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(master_ready), 32'h0);
      check("rst_error", 32'(master_error), 32'h0);
      check("rst_readdata", master_readdata, 32'h0);
      check("rst_strobes", 32'({slave_write, slave_read}), 32'h0);
      check("rst_address", 32'(slave_address), 32'h0);
      check("rst_be", 32'(slave_byte_enable), 32'h0);
      check("rst_wdata", slave_writedata, 32'h0);
      rst = 1'b0;

      // no request: stays idle
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (master_ready !== 1'b0 || {slave_write, slave_read} !== 6'b000000) cnt++;
      end
      check("idle_quiet", 32'(cnt), 32'h0);

      run_txn(1'b1, 1'b0, 32'h004, 32'hF, 32'h0, 0);       // RAM read, first-cycle ack
      run_txn(1'b0, 1'b1, 32'h214, 32'h3, 32'h3FF, 0);     // LEDR write
      run_txn(1'b1, 1'b0, 32'h300, 32'hF, 32'h0, 0);       // unmapped
      run_txn(1'b1, 1'b0, 32'h208, 32'hF, 32'h0, 99);      // SW never acks
      run_txn(1'b1, 1'b1, 32'h000, 32'hF, 32'h55, 0);      // read and write together
      run_txn(1'b1, 1'b0, 32'h20C, 32'hF, 32'h0, 15);      // ack on the last allowed cycle
      run_txn(1'b0, 1'b1, 32'h1FC, 32'hC, 32'hA5A5, 3);    // top of RAM, delayed write ack

      // reset in the middle of an access
      txn_id++;
      @(negedge clk);
      master_read = 1'b1; master_address = 10'h208;
      @(negedge clk);
      master_read = 1'b0;
      check("midrst_strobe_on", 32'({slave_write, slave_read}), 32'h02);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_strobe_off", 32'({slave_write, slave_read}), 32'h0);
      cnt = 0;
      repeat (4) begin
         if (master_ready !== 1'b0) cnt++;
         @(negedge clk);
      end
      check("midrst_no_ready", 32'(cnt), 32'h0);
      run_txn(1'b1, 1'b0, 32'h010, 32'hF, 32'h0, 1);       // fabric usable after reset

      // back-to-back: request held through ready restarts one cycle later
      txn_id++;
      slave_readdata[DW-1:0] = 32'h12345678;
      @(negedge clk);
      master_read = 1'b1; master_address = 10'h004; master_byte_enable = 4'hF;
      @(negedge clk);
      check("b2b_first_strobe", 32'(slave_read), 32'h1);
      slave_ack = 3'b001;
      @(negedge clk);
      slave_ack = 3'b000;
      check("b2b_first_ready", 32'(master_ready), 32'h1);
      check("b2b_first_data", master_readdata, 32'h12345678);
      @(negedge clk);
      check("b2b_gap_no_strobe", 32'(slave_read), 32'h0);
      @(negedge clk);
      check("b2b_second_strobe", 32'(slave_read), 32'h1);
      master_read = 1'b0;
      slave_ack = 3'b001;
      @(negedge clk);
      slave_ack = 3'b000;
      check("b2b_second_ready", 32'(master_ready), 32'h1);
      check("b2b_second_err", 32'(master_error), 32'h0);
      @(negedge clk);
      check("b2b_done", 32'(master_ready), 32'h0);

      // randomized transactions over all regions
      for (int k = 0; k < 40; k++) begin
         int sel, a, mode;
         sel = $urandom_range(0, 3);
         case (sel)
            0:       a = $urandom_range(0, 32'h1FF);
            1:       a = 32'h200 + $urandom_range(0, 15);
            2:       a = 32'h210 + $urandom_range(0, 15);
            default: a = 32'h220 + $urandom_range(0, 32'h1DF);
         endcase
         mode = $urandom_range(1, 3);
         r = $urandom;
         run_txn(mode[0], mode[1], a, $urandom_range(0, 15), r, $urandom_range(0, 17));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
